i2c_axil_slave_regs: RTL and testbench
======================================

# i2c_axil_slave_regs

AXI4-Lite responder for the I2C IP register window: accepts single-beat writes and reads from the AXI master and owns four 32-bit registers. It sits between the AXI interconnect (the VIP master in simulation) and the I2C engine. It drives the register contents and a start strobe to the engine, and returns register values on the read channel.

## Interface
- C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 supported
- C_S_AXI_ADDR_WIDTH, 4, byte address width; decode on ADDR[3:2]

- S_AXI_ACLK  in  1  clock, all logic rising-edge
- S_AXI_ARESET  in  1  synchronous, active-high reset
- S_AXI_AWADDR / AWPROT / AWVALID  in  4/3/1  write address; AWPROT ignored
- S_AXI_AWREADY  out  1  write address accepted
- S_AXI_WDATA / WSTRB / WVALID  in  32/4/1  write data, byte strobes
- S_AXI_WREADY  out  1  write data accepted
- S_AXI_BRESP / BVALID  out  2/1  write response
- S_AXI_BREADY  in  1  master accepts response
- S_AXI_ARADDR / ARPROT / ARVALID  in  4/3/1  read address; ARPROT ignored
- S_AXI_ARREADY  out  1  read address accepted
- S_AXI_RDATA / RRESP / RVALID  out  32/2/1  read data and response
- S_AXI_RREADY  in  1  master accepts read data
- reg0_o..reg3_o  out  32 each  current register contents (CTRL, TXDATA, CFG, AUX)
- start_o  out  1  one-cycle strobe on write to offset 0x0 with WSTRB[0]=1 and WDATA[0]=1
- status_i  in  32  engine status, used only with I2C_AXIL_STATUS_EN

## Operation
- Write channel: AW and W are latched independently, in either order or in the same cycle. Each is held in its own buffer (aw_held, w_held).
- Commit happens on the edge where both buffers are full, or fill in that cycle:
  - Register at ADDR[3:2] is updated byte-wise per WSTRB; lanes with strobe 0 keep their value.
  - BVALID is set; BRESP = OKAY (2'b00).
- Write FSM states: IDLE → (AW only) HAVE_ADDR / (W only) HAVE_DATA → RESP; IDLE → RESP directly when both arrive in the same cycle. RESP → IDLE on BVALID&&BREADY.
- Read FSM states: IDLE → DATA on ARVALID&&ARREADY. In that edge, RDATA captures the register value and RRESP = OKAY. DATA → IDLE on RVALID&&RREADY.
- Only one outstanding transaction per direction; there is no ID, burst, or pipelining.
- start_o pulses for one cycle at the commit edge. reg0 bit 0 is not self-clearing.

## Timing
- Reset values:
  - AWREADY, WREADY, ARREADY, BVALID, RVALID, start_o = 0.
  - BRESP, RRESP = 0.
  - RDATA = 0.
  - reg0..reg3 = 0.
  - Both FSMs go to IDLE; held buffers are cleared.
- AWREADY = !aw_held && !BVALID && !reset; WREADY = !w_held && !BVALID && !reset (registered equivalent permitted, same cycle behaviour).
- Write latency: BVALID rises 1 cycle after the last of the AW/W handshakes. reg*_o reflect the new value in the same cycle.
- ARREADY = !RVALID. RVALID rises 1 cycle after the AR handshake.
- BVALID and RVALID are held with stable data until their READY is sampled high. Back-pressure of any length is legal.
- Read and write to the same register committing on the same edge: the read returns the pre-write value.
- Reset asserted mid-transaction aborts it: the pending write is discarded, VALIDs drop at the next edge, and no response is issued.

## Configuration
- I2C_AXIL_STATUS_EN defined:
  - Offset 0x8 reads status_i, captured at the AR handshake edge.
  - Writes to 0x8 do not modify reg2 and return BRESP = SLVERR (2'b10).
  - reg2_o is tied to 0.
- Not defined: all four offsets are plain read/write and every response is OKAY.

## Structure
- Package i2c_axil_pkg:
  - register offset constants (REG_CTRL=0, REG_TXDATA=1, REG_CFG=2, REG_AUX=3 as word index)
  - resp constants (RESP_OKAY=2'b00, RESP_SLVERR=2'b10)
  - wr_state_t and rd_state_t enums
- One sub-module, i2c_axil_wr_chan: owns the AW/W buffers and the write FSM. It outputs the commit strobe, word index, data and strobes; the read channel and register file stay in the top.

## Test plan
- Sequential writes of 0x1,0x2,0x3,0x4 to 0x0,0x4,0x8,0xC, then reads of the same addresses → RDATA 0x1,0x2,0x3,0x4, all RRESP/BRESP=OKAY; start_o pulses exactly once (first write).
- W handshake 3 cycles before AW, with BREADY held low for 5 cycles → no commit until AW accepted; BVALID stays high and stable for 5 cycles; AWREADY/WREADY remain 0 meanwhile.
- Write 0xAABBCCDD to 0x4 with WSTRB=4'b0101 over a prior 0x11223344 → readback 0x11BB33DD.
- Read 0xC with RREADY low for 4 cycles while a write to 0xC commits → RDATA holds the old value for all 4 cycles; a subsequent read returns the new value.
- Assert S_AXI_ARESET for 1 cycle between AW handshake and W → no BVALID; later full write works; all regs read 0 except the new write.
- With I2C_AXIL_STATUS_EN, status_i=0xDEADBEEF: write 0x5 to 0x8 → BRESP=SLVERR; read 0x8 → 0xDEADBEEF.

Source files
------------

// File: rtl/i2c_axil_pkg.sv
// Shared constants and state types for the I2C AXI4-Lite register window.
// No logic, no latency; imported by the write channel and the top.
package i2c_axil_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_TXDATA = 2'd1;
  localparam logic [1:0] REG_CFG    = 2'd2;
  localparam logic [1:0] REG_AUX    = 2'd3;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_HAVE_ADDR,
    WR_HAVE_DATA,
    WR_RESP
  } wr_state_t;

  typedef enum logic {
    RD_IDLE,
    RD_DATA
  } rd_state_t;

  // Byte-lane merge: lanes with strobe 0 keep the old value.
  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = strb[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/i2c_axil_wr_chan.sv
// AXI4-Lite write channel: independent AW/W buffers, write FSM, commit strobe.
// Latency: commit on the edge completing the later of AW/W; BVALID one cycle later.
// Backpressure: AW/W ready only while their buffer is empty and no response is pending.
module i2c_axil_wr_chan
  import i2c_axil_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  aw_idx,
  input  logic        aw_vld,
  output logic        aw_rdy,
  input  logic [31:0] w_dat,
  input  logic [3:0]  w_strb,
  input  logic        w_vld,
  output logic        w_rdy,
  output logic [1:0]  b_resp,
  output logic        b_vld,
  input  logic        b_rdy,
  output logic        commit,
  output logic [1:0]  commit_idx,
  output logic [31:0] commit_dat,
  output logic [3:0]  commit_strb
);

  wr_state_t   state, state_nxt;
  logic [1:0]  addr_q;
  logic [31:0] data_q;
  logic [3:0]  strb_q;
  logic        aw_hs, w_hs;

  // A buffer is "held" in HAVE_ADDR/HAVE_DATA; RESP blocks both channels.
  assign aw_rdy = !rst && (state == WR_IDLE || state == WR_HAVE_DATA);
  assign w_rdy  = !rst && (state == WR_IDLE || state == WR_HAVE_ADDR);
  assign b_vld  = (state == WR_RESP);
  assign aw_hs  = aw_vld && aw_rdy;
  assign w_hs   = w_vld && w_rdy;

  always_comb begin
    state_nxt = state;
    case (state)
      WR_IDLE: begin
        if (aw_hs && w_hs) state_nxt = WR_RESP;
        else if (aw_hs)    state_nxt = WR_HAVE_ADDR;
        else if (w_hs)     state_nxt = WR_HAVE_DATA;
      end
      WR_HAVE_ADDR: if (w_hs)  state_nxt = WR_RESP;
      WR_HAVE_DATA: if (aw_hs) state_nxt = WR_RESP;
      WR_RESP:      if (b_rdy) state_nxt = WR_IDLE;
      default:      state_nxt = WR_IDLE;
    endcase
  end

  assign commit      = (state_nxt == WR_RESP) && (state != WR_RESP);
  assign commit_idx  = aw_hs ? aw_idx : addr_q;
  assign commit_dat  = w_hs  ? w_dat  : data_q;
  assign commit_strb = w_hs  ? w_strb : strb_q;

  always_ff @(posedge clk) begin
    if (rst) state <= WR_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
      data_q <= '0;
      strb_q <= '0;
      b_resp <= RESP_OKAY;
    end else begin
      if (aw_hs) addr_q <= aw_idx;
      if (w_hs) begin
        data_q <= w_dat;
        strb_q <= w_strb;
      end
      if (commit) begin
`ifdef I2C_AXIL_STATUS_EN
        b_resp <= (commit_idx == REG_CFG) ? RESP_SLVERR : RESP_OKAY;
`else
        b_resp <= RESP_OKAY;
`endif
      end
    end
  end

endmodule

// File: rtl/i2c_axil_slave_regs.sv
// AXI4-Lite responder owning four 32-bit I2C registers; optional I2C_AXIL_STATUS_EN maps status_i at 0x8.
// Latency: BVALID/RVALID one cycle after the final handshake; regs update at the commit edge.
// Backpressure: BVALID/RVALID hold stable until READY; one outstanding transaction per direction.
module i2c_axil_slave_regs
  import i2c_axil_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                          S_AXI_ACLK,
  input  logic                          S_AXI_ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_AWADDR,
  input  logic [2:0]                    S_AXI_AWPROT,
  input  logic                          S_AXI_AWVALID,
  output logic                          S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] S_AXI_WDATA,
  input  logic [3:0]                    S_AXI_WSTRB,
  input  logic                          S_AXI_WVALID,
  output logic                          S_AXI_WREADY,
  output logic [1:0]                    S_AXI_BRESP,
  output logic                          S_AXI_BVALID,
  input  logic                          S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
  input  logic [2:0]                    S_AXI_ARPROT,
  input  logic                          S_AXI_ARVALID,
  output logic                          S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0] S_AXI_RDATA,
  output logic [1:0]                    S_AXI_RRESP,
  output logic                          S_AXI_RVALID,
  input  logic                          S_AXI_RREADY,
  output logic [31:0]                   reg0_o,
  output logic [31:0]                   reg1_o,
  output logic [31:0]                   reg2_o,
  output logic [31:0]                   reg3_o,
  output logic                          start_o,
  input  logic [31:0]                   status_i
);

  logic        commit;
  logic [1:0]  commit_idx;
  logic [31:0] commit_dat;
  logic [3:0]  commit_strb;
  logic [31:0] regs [4];
  logic        start_q;
  rd_state_t   rd_state, rd_state_nxt;
  logic        ar_hs;
  logic [31:0] rd_mux;
  logic [31:0] rdata_q;
  logic        unused_ok;

  i2c_axil_wr_chan u_wr_chan (
    .clk         (S_AXI_ACLK),
    .rst         (S_AXI_ARESET),
    .aw_idx      (S_AXI_AWADDR[3:2]),
    .aw_vld      (S_AXI_AWVALID),
    .aw_rdy      (S_AXI_AWREADY),
    .w_dat       (S_AXI_WDATA),
    .w_strb      (S_AXI_WSTRB),
    .w_vld       (S_AXI_WVALID),
    .w_rdy       (S_AXI_WREADY),
    .b_resp      (S_AXI_BRESP),
    .b_vld       (S_AXI_BVALID),
    .b_rdy       (S_AXI_BREADY),
    .commit      (commit),
    .commit_idx  (commit_idx),
    .commit_dat  (commit_dat),
    .commit_strb (commit_strb)
  );

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      for (int i = 0; i < 4; i++) regs[i] <= '0;
      start_q <= 1'b0;
    end else begin
      start_q <= commit && (commit_idx == REG_CTRL) && commit_strb[0] && commit_dat[0];
`ifdef I2C_AXIL_STATUS_EN
      if (commit && commit_idx != REG_CFG)
`else
      if (commit)
`endif
        regs[commit_idx] <= apply_wstrb(regs[commit_idx], commit_dat, commit_strb);
    end
  end

  assign reg0_o  = regs[REG_CTRL];
  assign reg1_o  = regs[REG_TXDATA];
  assign reg3_o  = regs[REG_AUX];
  assign start_o = start_q;

  // Read side samples the register array before this edge's write lands.
  always_comb begin
    rd_mux = '0;
    case (S_AXI_ARADDR[3:2])
      REG_CTRL:   rd_mux = regs[REG_CTRL];
      REG_TXDATA: rd_mux = regs[REG_TXDATA];
`ifdef I2C_AXIL_STATUS_EN
      REG_CFG:    rd_mux = status_i;
`else
      REG_CFG:    rd_mux = regs[REG_CFG];
`endif
      REG_AUX:    rd_mux = regs[REG_AUX];
      default:    rd_mux = '0;
    endcase
  end

  assign S_AXI_ARREADY = !S_AXI_ARESET && (rd_state == RD_IDLE);
  assign S_AXI_RVALID  = (rd_state == RD_DATA);
  assign S_AXI_RRESP   = RESP_OKAY;
  assign S_AXI_RDATA   = rdata_q;
  assign ar_hs         = S_AXI_ARVALID && S_AXI_ARREADY;

  always_comb begin
    rd_state_nxt = rd_state;
    case (rd_state)
      RD_IDLE: if (ar_hs)         rd_state_nxt = RD_DATA;
      RD_DATA: if (S_AXI_RREADY)  rd_state_nxt = RD_IDLE;
      default:                    rd_state_nxt = RD_IDLE;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      rd_state <= RD_IDLE;
      rdata_q  <= '0;
    end else begin
      rd_state <= rd_state_nxt;
      if (ar_hs) rdata_q <= rd_mux;
    end
  end

`ifdef I2C_AXIL_STATUS_EN
  assign reg2_o    = '0;
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0],
                       S_AXI_ARADDR[1:0], regs[REG_CFG]};
`else
  assign reg2_o    = regs[REG_CFG];
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0],
                       S_AXI_ARADDR[1:0], status_i};
`endif

endmodule

// File: tb/tb_i2c_axil_slave_regs.sv
// Scoreboard bench for i2c_axil_slave_regs: stimulus pushes expected B/R responses, a monitor pops on handshake.
module tb_i2c_axil_slave_regs;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic [31:0] reg0, reg1, reg2, reg3;
  logic        start;
  logic [31:0] status;

  int compares   = 0;
  int mismatches = 0;
  int start_cnt  = 0;
  logic [1:0]  b_q [$];
  logic [31:0] r_q [$];

`ifdef I2C_AXIL_STATUS_EN
  localparam logic [1:0]  CFG_RESP = 2'b10;
  localparam logic [31:0] CFG_RD1  = 32'hDEADBEEF;
  localparam logic [31:0] CFG_RD5  = 32'hDEADBEEF;
`else
  localparam logic [1:0]  CFG_RESP = 2'b00;
  localparam logic [31:0] CFG_RD1  = 32'h00000003;
  localparam logic [31:0] CFG_RD5  = 32'hCAFE0000;
`endif

  always #5 clk = ~clk;

  i2c_axil_slave_regs dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESET  (rst),
    .S_AXI_AWADDR  (awaddr),
    .S_AXI_AWPROT  (awprot),
    .S_AXI_AWVALID (awvalid),
    .S_AXI_AWREADY (awready),
    .S_AXI_WDATA   (wdata),
    .S_AXI_WSTRB   (wstrb),
    .S_AXI_WVALID  (wvalid),
    .S_AXI_WREADY  (wready),
    .S_AXI_BRESP   (bresp),
    .S_AXI_BVALID  (bvalid),
    .S_AXI_BREADY  (bready),
    .S_AXI_ARADDR  (araddr),
    .S_AXI_ARPROT  (arprot),
    .S_AXI_ARVALID (arvalid),
    .S_AXI_ARREADY (arready),
    .S_AXI_RDATA   (rdata),
    .S_AXI_RRESP   (rresp),
    .S_AXI_RVALID  (rvalid),
    .S_AXI_RREADY  (rready),
    .reg0_o        (reg0),
    .reg1_o        (reg1),
    .reg2_o        (reg2),
    .reg3_o        (reg3),
    .start_o       (start),
    .status_i      (status)
  );

  always @(negedge clk) if (start) start_cnt++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compares++;
    if (act !== exp) begin
      mismatches++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    compares++;
    mismatches++;
    $display("FAIL %s: condition not met", name);
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (bvalid && bready) begin
        if (b_q.size() == 0) flag("unexpected_bresp");
        else check("bresp", {30'd0, bresp}, {30'd0, b_q.pop_front()});
      end
      if (rvalid && rready) begin
        if (r_q.size() == 0) flag("unexpected_rdata");
        else begin
          check("rdata", rdata, r_q.pop_front());
          check("rresp", {30'd0, rresp}, 32'd0);
        end
      end
    end
  endtask

  task automatic wait_b();
    int n = 0;
    while (n < 50) begin
      @(negedge clk);
      if (bvalid && bready) break;
      n++;
    end
    if (n == 50) flag("bvalid_timeout");
    else begin @(posedge clk); #1; end
  endtask

  task automatic wait_r();
    int n = 0;
    while (n < 50) begin
      @(negedge clk);
      if (rvalid && rready) break;
      n++;
    end
    if (n == 50) flag("rvalid_timeout");
    else begin @(posedge clk); #1; end
  endtask

  task automatic axi_write(input logic [3:0] a, input logic [31:0] d,
                           input logic [3:0] s, input logic [1:0] resp);
    bit aw_pend = 1'b1, w_pend = 1'b1, ag, wg;
    int n = 0;
    b_q.push_back(resp);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    while ((aw_pend || w_pend) && n < 50) begin
      @(negedge clk);
      ag = awvalid && awready;
      wg = wvalid && wready;
      @(posedge clk); #1;
      if (ag) begin awvalid = 1'b0; aw_pend = 1'b0; end
      if (wg) begin wvalid = 1'b0; w_pend = 1'b0; end
      n++;
    end
    if (aw_pend || w_pend) begin
      flag("write_hs_timeout");
      awvalid = 1'b0; wvalid = 1'b0;
    end else wait_b();
  endtask

  task automatic axi_read(input logic [3:0] a, input logic [31:0] exp);
    int n = 0;
    r_q.push_back(exp);
    araddr = a; arvalid = 1'b1;
    while (n < 50) begin
      @(negedge clk);
      if (arready) break;
      n++;
    end
    @(posedge clk); #1;
    arvalid = 1'b0;
    if (n == 50) flag("read_hs_timeout");
    else wait_r();
  endtask

  task automatic stimulus();
    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_awready", {31'd0, awready}, 32'd0);
    check("rst_wready",  {31'd0, wready},  32'd0);
    check("rst_arready", {31'd0, arready}, 32'd0);
    check("rst_bvalid",  {31'd0, bvalid},  32'd0);
    check("rst_rvalid",  {31'd0, rvalid},  32'd0);
    check("rst_start",   {31'd0, start},   32'd0);
    check("rst_bresp",   {30'd0, bresp},   32'd0);
    check("rst_rresp",   {30'd0, rresp},   32'd0);
    check("rst_rdata",   rdata, 32'd0);
    check("rst_regs",    reg0 | reg1 | reg2 | reg3, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("idle_awready", {31'd0, awready}, 32'd1);
    @(posedge clk); #1;

    // Sequential writes then readback
    axi_write(4'h0, 32'h1, 4'hF, 2'b00);
    axi_write(4'h4, 32'h2, 4'hF, 2'b00);
    axi_write(4'h8, 32'h3, 4'hF, CFG_RESP);
    axi_write(4'hC, 32'h4, 4'hF, 2'b00);
    axi_read(4'h0, 32'h1);
    axi_read(4'h4, 32'h2);
    axi_read(4'h8, CFG_RD1);
    axi_read(4'hC, 32'h4);
    check("t1_reg0", reg0, 32'h1);
    check("t1_reg3", reg3, 32'h4);
    check("t1_start_cnt", start_cnt, 32'd1);

    // W three cycles ahead of AW, B back-pressured for five cycles
    bready = 1'b0;
    wdata = 32'h11223344; wstrb = 4'hF; wvalid = 1'b1;
    @(negedge clk);
    check("t2_wready", {31'd0, wready}, 32'd1);
    @(posedge clk); #1;
    wvalid = 1'b0;
    b_q.push_back(2'b00);
    repeat (2) begin
      @(negedge clk);
      check("t2_no_bvalid", {31'd0, bvalid}, 32'd0);
      check("t2_wready_held", {31'd0, wready}, 32'd0);
      check("t2_no_commit", reg1, 32'h2);
    end
    @(posedge clk); #1;
    awaddr = 4'h4; awvalid = 1'b1;
    @(negedge clk);
    check("t2_awready", {31'd0, awready}, 32'd1);
    @(posedge clk); #1;
    awvalid = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("t2_bvalid_hold", {31'd0, bvalid}, 32'd1);
      check("t2_bresp_hold",  {30'd0, bresp},  32'd0);
      check("t2_awready_blk", {31'd0, awready}, 32'd0);
      check("t2_wready_blk",  {31'd0, wready},  32'd0);
      check("t2_reg1", reg1, 32'h11223344);
    end
    @(posedge clk); #1;
    bready = 1'b1;
    wait_b();

    // Partial strobes
    axi_write(4'h4, 32'hAABBCCDD, 4'b0101, 2'b00);
    axi_read(4'h4, 32'h11BB33DD);

    // Read of 0xC held off while a write to 0xC commits on the same edge
    rready = 1'b0;
    araddr = 4'hC; awaddr = 4'hC; wdata = 32'h55667788; wstrb = 4'hF;
    r_q.push_back(32'h4);
    b_q.push_back(2'b00);
    arvalid = 1'b1; awvalid = 1'b1; wvalid = 1'b1;
    @(negedge clk);
    check("t4_all_rdy", {29'd0, arready, awready, wready}, 32'd7);
    @(posedge clk); #1;
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("t4_rvalid_hold", {31'd0, rvalid}, 32'd1);
      check("t4_rdata_old", rdata, 32'h4);
      check("t4_reg3_new", reg3, 32'h55667788);
    end
    @(posedge clk); #1;
    rready = 1'b1;
    wait_r();
    axi_read(4'hC, 32'h55667788);

    // Reset between AW handshake and W aborts the write
    awaddr = 4'h4; awvalid = 1'b1;
    @(negedge clk);
    check("t5_awready", {31'd0, awready}, 32'd1);
    @(posedge clk); #1;
    awvalid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("t5_no_bvalid", {31'd0, bvalid}, 32'd0);
      check("t5_buf_clear", {30'd0, awready, wready}, 32'd3);
    end
    @(posedge clk); #1;
    axi_write(4'h8, 32'hCAFE0000, 4'hF, CFG_RESP);
    axi_read(4'h0, 32'h0);
    axi_read(4'h4, 32'h0);
    axi_read(4'h8, CFG_RD5);
    axi_read(4'hC, 32'h0);
    check("t5_start_cnt", start_cnt, 32'd1);

`ifdef I2C_AXIL_STATUS_EN
    axi_write(4'h8, 32'h5, 4'hF, 2'b10);
    axi_read(4'h8, 32'hDEADBEEF);
    check("t6_reg2_tied", reg2, 32'h0);
`endif

    repeat (3) @(negedge clk);
    check("b_q_drained", 32'(b_q.size()), 32'd0);
    check("r_q_drained", 32'(r_q.size()), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    awaddr = '0; awprot = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b1;
    araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b1;
    status = 32'hDEADBEEF;
    fork
      monitor();
      stimulus();
    join_any
    disable fork;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, mismatches);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
